// File: rtl/alu_operations.sv
`default_nettype none
// ============================================================================
// Module  : alu_operations
// Brief   : Operation encodings understood by the shared ALU.
// Revision: 1.0 - initial release
// ============================================================================
package alu_operations;

    localparam logic [3:0] ADDITION    = 4'd0;
    localparam logic [3:0] SUBTRACTION = 4'd1;
    localparam logic [3:0] BITWISE_AND = 4'd2;
    localparam logic [3:0] BITWISE_OR  = 4'd3;
    localparam logic [3:0] BITWISE_XOR = 4'd4;
    localparam logic [3:0] SHIFT_LEFT  = 4'd5;
    localparam logic [3:0] SHIFT_RIGHT = 4'd6;

endpackage
`default_nettype wire

// File: rtl/alu_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_scheduler_pkg
// Brief   : Shared types and constants for the ALU scheduler slice.
// Revision: 1.0 - initial release
// ============================================================================
package alu_scheduler_pkg;

    localparam int c_OP_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_scheduler_if
// Brief   : Requester-side give/get bundle of the ALU scheduler.
// Revision: 1.0 - initial release
// ============================================================================
interface alu_scheduler_if #(
    parameter int BITSIZE = 32,
    parameter int NUM_REQ = 2
);
    import alu_scheduler_pkg::*;

    logic [NUM_REQ-1:0]         REQ_give_i;
    logic [NUM_REQ-1:0]         ARB_get_o;
    logic [NUM_REQ*BITSIZE-1:0] REQ_a_i;
    logic [NUM_REQ*BITSIZE-1:0] REQ_b_i;
    logic [NUM_REQ*c_OP_W-1:0]  REQ_op_i;
    logic [NUM_REQ-1:0]         ARB_give_o;
    logic [NUM_REQ-1:0]         REQ_get_i;
    logic [BITSIZE-1:0]         ARB_r_o;
    logic                       ARB_overflow_o;

    modport master (
        output REQ_give_i, REQ_a_i, REQ_b_i, REQ_op_i, REQ_get_i,
        input  ARB_get_o, ARB_give_o, ARB_r_o, ARB_overflow_o
    );

    modport slave (
        input  REQ_give_i, REQ_a_i, REQ_b_i, REQ_op_i, REQ_get_i,
        output ARB_get_o, ARB_give_o, ARB_r_o, ARB_overflow_o
    );

endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module  : alu
// Brief   : Combinational ALU; overflow is signed overflow for add/subtract.
// Revision: 1.0 - initial release
// ============================================================================
module alu
    import alu_operations::*;
#(
    parameter int BITSIZE = 32
) (
    input  wire logic [BITSIZE-1:0] A_i,
    input  wire logic [BITSIZE-1:0] B_i,
    input  wire logic [3:0]         operation_i,
    output logic      [BITSIZE-1:0] R_o,
    output logic                    overflow_o
);

    localparam int c_SH_W = $clog2(BITSIZE);

    always_comb begin
        R_o        = '0;
        overflow_o = 1'b0;
        case (operation_i)
            ADDITION: begin
                R_o        = A_i + B_i;
                overflow_o = (A_i[BITSIZE-1] == B_i[BITSIZE-1]) &&
                             (R_o[BITSIZE-1] != A_i[BITSIZE-1]);
            end
            SUBTRACTION: begin
                R_o        = A_i - B_i;
                overflow_o = (A_i[BITSIZE-1] != B_i[BITSIZE-1]) &&
                             (R_o[BITSIZE-1] != A_i[BITSIZE-1]);
            end
            BITWISE_AND: R_o = A_i & B_i;
            BITWISE_OR:  R_o = A_i | B_i;
            BITWISE_XOR: R_o = A_i ^ B_i;
            SHIFT_LEFT:  R_o = A_i << B_i[c_SH_W-1:0];
            SHIFT_RIGHT: R_o = A_i >> B_i[c_SH_W-1:0];
            default:     R_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin arbiter; search starts at i_ptr.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N    = 2,
    localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic [N-1:0]    i_req,
    input  wire logic [ID_W-1:0] i_ptr,
    output logic      [N-1:0]    o_grant,
    output logic      [ID_W-1:0] o_id
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_grant = '0;
        o_id    = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_id           = ID_W'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : alu_scheduler
// Brief   : Round-robin sharing of one ALU between NUM_REQ give/get requesters.
// Revision: 1.0 - initial release
// ============================================================================
module alu_scheduler
    import alu_scheduler_pkg::*;
#(
    parameter int BITSIZE = 32,
    parameter int NUM_REQ = 2
) (
    input  wire logic          clk,
    input  wire logic          resetn_i,
    alu_scheduler_if.slave     bus,
    output logic               busy_o
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_t               r_state;
    state_t               w_next;
    logic [NUM_REQ-1:0]   w_grant;
    logic [ID_W-1:0]      w_id;
    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      r_id;
    logic [BITSIZE-1:0]   r_a;
    logic [BITSIZE-1:0]   r_b;
    logic [c_OP_W-1:0]    r_op;
    logic [BITSIZE-1:0]   r_res;
    logic                 r_ovf;
    logic [BITSIZE-1:0]   w_alu_r;
    logic                 w_alu_ovf;
    logic                 w_accept;
    logic                 w_taken;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_req   (bus.REQ_give_i),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_id    (w_id)
    );

    alu #(.BITSIZE(BITSIZE)) u_alu (
        .A_i         (r_a),
        .B_i         (r_b),
        .operation_i (r_op),
        .R_o         (w_alu_r),
        .overflow_o  (w_alu_ovf)
    );

    // No handshake may complete while reset is held.
    assign w_accept = resetn_i && (r_state == IDLE) && (|w_grant);
    assign w_taken  = (r_state == RESP) && bus.REQ_get_i[r_id];

    always_ff @(posedge clk) begin
        if (!resetn_i) r_state <= IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|w_grant) w_next = EXEC;
            EXEC:    w_next = RESP;
            RESP:    if (w_taken) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ARB_get_o  = '0;
        bus.ARB_give_o = '0;
        busy_o         = (r_state != IDLE);
        if (resetn_i) begin
            if (r_state == IDLE) bus.ARB_get_o        = w_grant;
            if (r_state == RESP) bus.ARB_give_o[r_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn_i) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_id  <= '0;
            r_ptr <= '0;
            r_res <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a  <= bus.REQ_a_i[w_id*BITSIZE +: BITSIZE];
                r_b  <= bus.REQ_b_i[w_id*BITSIZE +: BITSIZE];
                r_op <= bus.REQ_op_i[w_id*c_OP_W +: c_OP_W];
                r_id <= w_id;
            end
            if (r_state == EXEC) begin
                r_res <= w_alu_r;
                r_ovf <= w_alu_ovf;
            end
            if (w_taken) begin
                r_ptr <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
            end
        end
    end

    assign bus.ARB_r_o        = r_res;
    assign bus.ARB_overflow_o = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_scheduler
// Brief   : Directed self-checking bench for alu_scheduler (two requesters).
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_scheduler;
    import alu_operations::*;

    localparam int BITSIZE = 32;
    localparam int NUM_REQ = 2;

    logic clk = 1'b0;
    logic resetn_i;
    logic busy_o;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    alu_scheduler_if #(.BITSIZE(BITSIZE), .NUM_REQ(NUM_REQ)) bus ();

    alu_scheduler #(.BITSIZE(BITSIZE), .NUM_REQ(NUM_REQ)) dut (
        .clk      (clk),
        .resetn_i (resetn_i),
        .bus      (bus),
        .busy_o   (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
        bus.REQ_a_i[i*BITSIZE +: BITSIZE] = a;
        bus.REQ_b_i[i*BITSIZE +: BITSIZE] = b;
        bus.REQ_op_i[i*4 +: 4]            = op;
    endtask

    // Entered at a negedge in IDLE with requests applied; leaves at a negedge in IDLE.
    task automatic do_op(input string tag, input logic [1:0] exp_grant,
                         input logic [31:0] exp_r, input logic exp_ovf,
                         input logic [1:0] give_after);
        #1;
        check({tag, "/get"}, 32'(bus.ARB_get_o), 32'(exp_grant));
        tick();
        bus.REQ_give_i = give_after;
        #1;
        check({tag, "/exec_busy"}, 32'(busy_o), 32'd1);
        check({tag, "/exec_give"}, 32'(bus.ARB_give_o), 32'd0);
        check({tag, "/exec_get"}, 32'(bus.ARB_get_o), 32'd0);
        tick();
        check({tag, "/give"}, 32'(bus.ARB_give_o), 32'(exp_grant));
        check({tag, "/r"}, bus.ARB_r_o, exp_r);
        check({tag, "/ovf"}, 32'(bus.ARB_overflow_o), 32'(exp_ovf));
        bus.REQ_get_i = exp_grant;
        tick();
        bus.REQ_get_i = '0;
        check({tag, "/idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn_i       = 1'b0;
        bus.REQ_give_i = 2'b11;
        bus.REQ_get_i  = '0;
        bus.REQ_a_i    = '0;
        bus.REQ_b_i    = '0;
        bus.REQ_op_i   = '0;
        set_req(0, 32'd1, 32'd1, ADDITION);
        set_req(1, 32'd2, 32'd3, ADDITION);
        tick();

        // Reset held with both requesters asking
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst%0d/get", i), 32'(bus.ARB_get_o), 32'd0);
            check($sformatf("rst%0d/give", i), 32'(bus.ARB_give_o), 32'd0);
            check($sformatf("rst%0d/busy", i), 32'(busy_o), 32'd0);
            check($sformatf("rst%0d/r", i), bus.ARB_r_o, 32'd0);
            tick();
        end
        resetn_i       = 1'b1;
        bus.REQ_give_i = '0;
        tick();

        // Single request: 5 + 7
        set_req(0, 32'd5, 32'd7, ADDITION);
        bus.REQ_give_i = 2'b01;
        do_op("single", 2'b01, 32'd12, 1'b0, 2'b00);

        // Round-robin from a fresh pointer
        resetn_i = 1'b0;
        tick();
        resetn_i = 1'b1;
        set_req(0, 32'd1, 32'd1, ADDITION);
        set_req(1, 32'd10, 32'd20, ADDITION);
        bus.REQ_give_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            do_op($sformatf("rr%0d", k), (k % 2 == 1) ? 2'b10 : 2'b01,
                  (k % 2 == 1) ? 32'd30 : 32'd2, 1'b0, 2'b11);
        end
        bus.REQ_give_i = '0;

        // Backpressure on req1 while req0 keeps asking
        set_req(1, 32'd3, 32'd4, ADDITION);
        bus.REQ_give_i = 2'b10;
        #1;
        check("bp/get", 32'(bus.ARB_get_o), 32'h2);
        tick();
        bus.REQ_give_i = 2'b01;
        tick();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp%0d/give", i), 32'(bus.ARB_give_o), 32'h2);
            check($sformatf("bp%0d/r", i), bus.ARB_r_o, 32'd7);
            check($sformatf("bp%0d/get", i), 32'(bus.ARB_get_o), 32'd0);
            tick();
        end
        bus.REQ_get_i  = 2'b10;
        bus.REQ_give_i = '0;
        tick();
        bus.REQ_get_i = '0;
        check("bp/idle", 32'(busy_o), 32'd0);

        // Signed overflow and unsigned wrap
        set_req(0, 32'h7FFF_FFFF, 32'd1, ADDITION);
        bus.REQ_give_i = 2'b01;
        do_op("ovf", 2'b01, 32'h8000_0000, 1'b1, 2'b00);
        set_req(0, 32'hFFFF_FFFF, 32'd1, ADDITION);
        bus.REQ_give_i = 2'b01;
        do_op("wrap", 2'b01, 32'h0000_0000, 1'b0, 2'b00);

        // Reset during EXEC; pointer was 1 beforehand
        set_req(0, 32'd50, 32'd60, ADDITION);
        bus.REQ_give_i = 2'b01;
        #1;
        check("mid/get", 32'(bus.ARB_get_o), 32'h1);
        tick();
        bus.REQ_give_i = '0;
        resetn_i       = 1'b0;
        #1;
        check("mid/exec_busy", 32'(busy_o), 32'd1);
        tick();
        check("mid/rst_give", 32'(bus.ARB_give_o), 32'd0);
        check("mid/rst_busy", 32'(busy_o), 32'd0);
        resetn_i = 1'b1;
        tick();
        check("mid/after_give", 32'(bus.ARB_give_o), 32'd0);
        check("mid/after_busy", 32'(busy_o), 32'd0);
        check("mid/after_r", bus.ARB_r_o, 32'd0);

        set_req(0, 32'd1, 32'd1, ADDITION);
        set_req(1, 32'd100, 32'd23, SUBTRACTION);
        bus.REQ_give_i = 2'b11;
        do_op("ptr0", 2'b01, 32'd2, 1'b0, 2'b10);
        do_op("req1", 2'b10, 32'd77, 1'b0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_scheduler.md
Name: alu_scheduler

Overview:
- Shares one ALU instance between NUM_REQ requesters, e.g. the execute stage and a branch/address-generation unit.
- Arbitrates round-robin, latches the winning operands and operation, sequences the ALU for one cycle, and holds the registered result until the owning requester takes it.
- All requester-side interfaces use the team's give/get handshake.

Parameters:
- BITSIZE, 32, operand/result width
- NUM_REQ, 2, number of requesters (2..4)
- ID_W, $clog2(NUM_REQ), requester index width (derived, not overridable)

Ports:
- clk  in  1  clock
- resetn_i  in  1  synchronous active-low reset
- REQ_give_i  in  NUM_REQ  per-requester request valid
- ARB_get_o  out  NUM_REQ  per-requester request accepted (one-hot or zero)
- REQ_a_i  in  NUM_REQ*BITSIZE  operand A, packed, requester i at [i*BITSIZE +: BITSIZE]
- REQ_b_i  in  NUM_REQ*BITSIZE  operand B, packed the same way
- REQ_op_i  in  NUM_REQ*4  ALU operation code, packed the same way
- ARB_give_o  out  NUM_REQ  per-requester result valid (one-hot or zero)
- REQ_get_i  in  NUM_REQ  per-requester result taken
- ARB_r_o  out  BITSIZE  result, shared bus
- ARB_overflow_o  out  1  overflow flag, shared bus
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, named resetn_i.
- Reset values:
  - state = IDLE, rr pointer = 0.
  - ARB_get_o = 0, ARB_give_o = 0, busy_o = 0.
  - Latched operands, op and id = 0; ARB_r_o = 0, ARB_overflow_o = 0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - winner = first i with REQ_give_i[i]=1, searching ptr, ptr+1, ... modulo NUM_REQ.
  - ARB_get_o[winner] = 1 combinationally; all other bits 0.
  - If no request is present, ARB_get_o = 0 and the state stays IDLE.
  - The handshake completes in the same cycle: latch that requester's a, b, op and id, then go to EXEC.
- EXEC:
  - The ALU is driven from the latched a, b and op.
  - At the clock edge, register the ALU result and overflow, then go to RESP.
  - ARB_get_o = 0.
- RESP:
  - ARB_give_o[id] = 1; ARB_r_o and ARB_overflow_o hold the registered values.
  - When REQ_get_i[id] = 1: set ptr = (id+1) mod NUM_REQ and go to IDLE.
  - REQ_get_i bits other than id are ignored.
- Latency and throughput:
  - Request accepted in cycle T; ARB_give_o asserted from T+2.
  - Minimum 3 cycles per operation: the next accept is possible in the cycle after the result get.
- Requester rules:
  - A requester holds give, a, b and op stable until it sees its get.
  - Operands may change freely after the accept cycle, because they are latched.
  - A request withdrawn before its get is legal and is simply not served.
- Fairness: after serving requester k, requester k+1 has top priority. With all requesters continuously requesting, service strictly rotates.
- ALU boundaries:
  - Operation codes are passed through unchanged; codes the ALU does not define yield whatever the ALU produces.
  - Results are BITSIZE wide, with no sign extension in this block.
- Reset mid-operation: any state returns to IDLE with the in-flight result discarded, and no give is asserted in the following cycle.
- A result is never dropped: the block waits in RESP indefinitely for its get.
- The ALU is instantiated internally (existing alu module, ports A_i, B_i, operation_i, R_o, overflow_o).

Decomposition:
- Shared package: state enum {IDLE, EXEC, RESP}; 4-bit ALU operation code width. The operation encodings themselves stay in the existing alu_operations definitions.
- One natural sub-module: rr_arbiter.
  - Inputs: req vector, ptr.
  - Output: one-hot grant plus encoded id.
  - Purely combinational, reusable for future shared resources.

Test Plan:
1. Reset: hold resetn_i=0 for 3 cycles with REQ_give_i=2'b11 -> ARB_get_o=0, ARB_give_o=0, busy_o=0 throughout.
2. Single request: req0 a=5, b=7, op=ADDITION -> ARB_get_o=2'b01 in cycle T, ARB_give_o=2'b01 at T+2 with ARB_r_o=12; REQ_get_i=01 at T+2 -> IDLE at T+3.
3. Round-robin: both requesters hold give continuously with distinct ops (req0 ADD 1+1, req1 ADD 10+20) -> grants in order 0,1,0,1 with results 2,30,2,30.
4. Backpressure: result for req1 ready, REQ_get_i held 0 for 10 cycles -> ARB_give_o=2'b10 and ARB_r_o stable all 10 cycles; no new ARB_get_o while in RESP.
5. Overflow/wrap: a=32'h7FFF_FFFF, b=1, ADDITION -> ARB_r_o=32'h8000_0000, ARB_overflow_o=1; a=32'hFFFF_FFFF, b=1 -> ARB_r_o=0.
6. Reset mid-operation: assert resetn_i=0 during EXEC -> next cycle IDLE, ARB_give_o=0, ptr=0; a subsequent req1-only request is served normally.
